game_ctrl: RTL and testbench
============================

Name: game_ctrl

Overview:
Top-level sequencing controller for the Tetris datapath. Drives the phase code (`state`/`old_state`) and the per-step `move` command into the datapath, and holds the board, location and rotation registers that feed back into it. Consumes the `touched` and `error` flags, paces gravity with a tick counter, and latches player button presses. It sits between the button/debounce front end and the datapath.

Parameters:
DROP_TICKS, 24'd1000000, clka cycles between gravity steps in MOVE (minimum 2).
TOP_ROW_MASK, 32'h0000000F, board bits forming the spawn row; any set bit at NEWBOARD ends the game.

Ports:
clka  in  1  system clock, rising edge.
restart  in  1  asynchronous, active-high reset.
btn_left  in  1  single-cycle debounced pulse: move left.
btn_right  in  1  single-cycle debounced pulse: move right.
btn_rotate  in  1  single-cycle debounced pulse: rotate.
btn_start  in  1  single-cycle pulse: leave GAMEOVER.
touched  in  1  datapath flag: piece cannot descend.
error_in  in  1  datapath redraw/clear error.
board_dp  in  32  board computed by the datapath.
location_dp  in  5  location computed by the datapath.
rotation_dp  in  2  rotation computed by the datapath.
state  out  3  current phase: GEN=0, MOVE=1, LAND=2, CLEAR=3, NEWBOARD=4, GAMEOVER=5.
old_state  out  3  phase of the previous cycle.
move  out  2  0 = gravity/none, 1 = left, 2 = right, 3 = rotate.
board_out  out  32  registered board, drives datapath board_in.
location_out  out  5  registered location, drives datapath location_in.
rotation_out  out  2  registered rotation, drives datapath rotation_in.
pieces  out  8  pieces landed, saturating at 255.
game_over  out  1  high while in GAMEOVER.

Behaviour:
- Reset (asynchronous):
  - `state` = GEN, `old_state` = GEN, `move` = 0.
  - `board_out` = 0, `location_out` = 0, `rotation_out` = 0.
  - `pieces` = 0, `game_over` = 0.
  - Tick counter = 0, pending command = none.
  - Reset asserted mid-game aborts everything in the same cycle.
- `old_state` <= `state` on every clock edge.
- Command latch:
  - A button pulse arriving while `state` = MOVE and no command is pending is latched.
  - Same-cycle priority: rotate > left > right.
  - Pulses arriving while a command is pending, or outside MOVE, are dropped.
- Tick counter:
  - Counts 0..DROP_TICKS-1 only in MOVE, then wraps.
  - `tick` = (count == DROP_TICKS-1).
  - Cleared on entry to MOVE.
- GEN: exactly 1 cycle.
  - `location_out` <= `location_dp`; `rotation_out` <= `rotation_dp`.
  - Next state: MOVE.
- MOVE, per cycle:
  - If a command is pending: `move` = command for exactly this cycle. `board_out`, `location_out` and `rotation_out` load from the dp inputs. The pending command clears.
  - Else if `tick`: `move` = 0 and the registers load from the dp inputs. If `touched` = 1 in this cycle, next state is LAND.
  - Else: `move` = 0 and all registers hold.
  - A pending command and `tick` in the same cycle: the command wins and the tick is deferred one cycle (the counter holds at DROP_TICKS-1).
  - `touched` is ignored on command cycles.
- LAND: 1 cycle.
  - `board_out` <= `board_dp`.
  - `pieces` increments (saturating).
  - Next state: CLEAR.
- CLEAR: 1 cycle.
  - `board_out` <= `board_dp`.
  - Next state: GAMEOVER if `error_in`, else NEWBOARD.
- NEWBOARD: 1 cycle.
  - If (`board_out` & TOP_ROW_MASK) != 0, next state is GAMEOVER; else GEN.
  - `rotation_out` <= 0.
- GAMEOVER:
  - `game_over` = 1; all registers hold.
  - `btn_start` clears the board, location, rotation and `pieces`, then goes to GEN.
  - Buttons other than `btn_start` are ignored.
- Undefined codes 6 and 7 go to GAMEOVER on the next edge.
- All outputs are registered, except `move` and `game_over`, which decode combinationally from `state` and the pending register.

Decomposition:
- Shared package holds:
  - Phase constants GEN..GAMEOVER, 3 bits.
  - Move codes MV_NONE=0, MV_LEFT=1, MV_RIGHT=2, MV_ROT=3.
  - BOARD_W = 32.
- One sub-module, `drop_timer`: parameterised tick counter with enable and synchronous clear, outputting `tick`.

Test Plan:
1. Reset, then release with DROP_TICKS=4 → `state` sequence GEN, MOVE; `old_state` lags by one cycle; `move` = 0; `board_out` = 0.
2. In MOVE, assert `btn_left` and `btn_rotate` in the same cycle → next cycle `move` = 3 for exactly one cycle; `location_out`/`rotation_out` load the dp values (e.g. 5'd6 / 2'd1); no second command is issued.
3. Hold `touched` = 1 with DROP_TICKS=4 → the 4th MOVE cycle has `move` = 0 and the next state is LAND, then CLEAR, then NEWBOARD; `pieces` goes from 0 to 1.
4. `btn_right` pending on a tick cycle → `move` = 2 that cycle, and the tick executes the following cycle.
5. At NEWBOARD, drive `board_dp` = 32'h00000003 during CLEAR → GAMEOVER and `game_over` = 1; a `btn_start` pulse → GEN with `board_out` = 0 and `pieces` = 0.
6. `error_in` = 1 during CLEAR → GAMEOVER; asserting `restart` mid-MOVE → all outputs at their reset values before the next clock edge.

Source files
------------

// File: rtl/game_ctrl_pkg.sv
// Shared types and constants for the Tetris sequencing controller.
// Holds the phase codes, move codes, the pending-command payload and the
// button-priority helper used when latching player input.
package game_ctrl_pkg;

    localparam int unsigned BOARD_W = 32;
    localparam int unsigned LOC_W   = 5;
    localparam int unsigned ROT_W   = 2;
    localparam int unsigned PHASE_W = 3;
    localparam int unsigned MOVE_W  = 2;
    localparam int unsigned PIECE_W = 8;

    typedef enum logic [PHASE_W-1:0] {
        GEN      = 3'd0,
        MOVE     = 3'd1,
        LAND     = 3'd2,
        CLEAR    = 3'd3,
        NEWBOARD = 3'd4,
        GAMEOVER = 3'd5
    } phase_e;

    typedef enum logic [MOVE_W-1:0] {
        MV_NONE  = 2'd0,
        MV_LEFT  = 2'd1,
        MV_RIGHT = 2'd2,
        MV_ROT   = 2'd3
    } move_e;

    typedef struct packed {
        logic  valid;
        move_e cmd;
    } cmd_t;

    // Same-cycle button priority: rotate beats left beats right.
    function automatic cmd_t pick_cmd(input logic rot, input logic left, input logic right);
        cmd_t c;
        c.valid = rot | left | right;
        if (rot)        c.cmd = MV_ROT;
        else if (left)  c.cmd = MV_LEFT;
        else if (right) c.cmd = MV_RIGHT;
        else            c.cmd = MV_NONE;
        return c;
    endfunction

endpackage

// File: rtl/game_ctrl_if.sv
// Bundle of button, datapath-feedback and controller-output signals.
//   master: the controller (consumes buttons/datapath, drives phase/move/registers)
//   slave : the button front end plus datapath side
interface game_ctrl_if;
    import game_ctrl_pkg::*;

    logic                btn_left;
    logic                btn_right;
    logic                btn_rotate;
    logic                btn_start;
    logic                touched;
    logic                error_in;
    logic [BOARD_W-1:0]  board_dp;
    logic [LOC_W-1:0]    location_dp;
    logic [ROT_W-1:0]    rotation_dp;

    logic [PHASE_W-1:0]  state;
    logic [PHASE_W-1:0]  old_state;
    logic [MOVE_W-1:0]   move;
    logic [BOARD_W-1:0]  board_out;
    logic [LOC_W-1:0]    location_out;
    logic [ROT_W-1:0]    rotation_out;
    logic [PIECE_W-1:0]  pieces;
    logic                game_over;

    modport master (
        input  btn_left, btn_right, btn_rotate, btn_start,
        input  touched, error_in, board_dp, location_dp, rotation_dp,
        output state, old_state, move, board_out, location_out,
        output rotation_out, pieces, game_over
    );

    modport slave (
        output btn_left, btn_right, btn_rotate, btn_start,
        output touched, error_in, board_dp, location_dp, rotation_dp,
        input  state, old_state, move, board_out, location_out,
        input  rotation_out, pieces, game_over
    );

endinterface

// File: rtl/game_ctrl_drop.sv
// Gravity pacing counter: counts 0..TICKS-1 while enabled, then wraps.
//   clk, rst : clock, async active-high reset
//   en       : advance the count this cycle
//   clr      : synchronous clear (wins over en)
//   tick     : count is at its last value
module drop_timer #(
    parameter int unsigned TICKS = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CNT_W = (TICKS > 1) ? $clog2(TICKS) : 1;

    logic [CNT_W-1:0] count_q, count_d;

    assign tick = (count_q == CNT_W'(TICKS - 1));

    // Next count
    always_comb begin
        count_d = count_q;
        if (clr)      count_d = '0;
        else if (en)  count_d = tick ? '0 : count_q + CNT_W'(1);
    end

    // Count register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

endmodule

// File: rtl/game_ctrl.sv
// Tetris sequencing controller: steps the datapath through
// GEN -> MOVE -> LAND -> CLEAR -> NEWBOARD, paces gravity, latches one
// player command at a time and owns the board/location/rotation registers.
//   clka    : clock
//   restart : async active-high reset
//   bus     : button, datapath and phase/register signals (master side)
// move and game_over decode combinationally from the phase and pending command;
// every other output is a flop.
module game_ctrl
    import game_ctrl_pkg::*;
#(
    parameter int unsigned         DROP_TICKS   = 1000000,
    parameter logic [BOARD_W-1:0]  TOP_ROW_MASK = 32'h0000000F
) (
    input  logic        clka,
    input  logic        restart,
    game_ctrl_if.master bus
);

    phase_e              state_q, state_d;
    logic [PHASE_W-1:0]  old_state_q;
    logic [BOARD_W-1:0]  board_q, board_d;
    logic [LOC_W-1:0]    loc_q, loc_d;
    logic [ROT_W-1:0]    rot_q, rot_d;
    logic [PIECE_W-1:0]  pieces_q, pieces_d;
    cmd_t                pend_q, pend_d;

    logic tick;
    logic tmr_en;
    logic tmr_clr;

    drop_timer #(.TICKS(DROP_TICKS)) u_drop (
        .clk  (clka),
        .rst  (restart),
        .en   (tmr_en),
        .clr  (tmr_clr),
        .tick (tick)
    );

    // Next phase, register loads and command latch
    always_comb begin
        state_d  = state_q;
        board_d  = board_q;
        loc_d    = loc_q;
        rot_d    = rot_q;
        pieces_d = pieces_q;
        pend_d   = '0;
        tmr_en   = 1'b0;
        // Holding the counter cleared outside MOVE zeroes it on entry.
        tmr_clr  = (state_q != MOVE);

        case (state_q)
            GEN: begin
                loc_d   = bus.location_dp;
                rot_d   = bus.rotation_dp;
                state_d = MOVE;
            end
            MOVE: begin
                // A command coinciding with a tick parks the counter on the tick value.
                tmr_en = !(pend_q.valid && tick);
                if (pend_q.valid) begin
                    board_d = bus.board_dp;
                    loc_d   = bus.location_dp;
                    rot_d   = bus.rotation_dp;
                end else begin
                    pend_d = pick_cmd(bus.btn_rotate, bus.btn_left, bus.btn_right);
                    if (tick) begin
                        board_d = bus.board_dp;
                        loc_d   = bus.location_dp;
                        rot_d   = bus.rotation_dp;
                        if (bus.touched) state_d = LAND;
                    end
                end
            end
            LAND: begin
                board_d  = bus.board_dp;
                pieces_d = (pieces_q == '1) ? pieces_q : pieces_q + PIECE_W'(1);
                state_d  = CLEAR;
            end
            CLEAR: begin
                board_d = bus.board_dp;
                state_d = bus.error_in ? GAMEOVER : NEWBOARD;
            end
            NEWBOARD: begin
                rot_d   = '0;
                state_d = ((board_q & TOP_ROW_MASK) != '0) ? GAMEOVER : GEN;
            end
            GAMEOVER: begin
                if (bus.btn_start) begin
                    board_d  = '0;
                    loc_d    = '0;
                    rot_d    = '0;
                    pieces_d = '0;
                    state_d  = GEN;
                end
            end
            default: state_d = GAMEOVER;
        endcase
    end

    // State and datapath-feedback registers
    always_ff @(posedge clka or posedge restart) begin
        if (restart) begin
            state_q     <= GEN;
            old_state_q <= PHASE_W'(GEN);
            board_q     <= '0;
            loc_q       <= '0;
            rot_q       <= '0;
            pieces_q    <= '0;
            pend_q      <= '0;
        end else begin
            state_q     <= state_d;
            old_state_q <= state_q;
            board_q     <= board_d;
            loc_q       <= loc_d;
            rot_q       <= rot_d;
            pieces_q    <= pieces_d;
            pend_q      <= pend_d;
        end
    end

    assign bus.state        = state_q;
    assign bus.old_state    = old_state_q;
    assign bus.move         = (state_q == MOVE && pend_q.valid) ? pend_q.cmd : MV_NONE;
    assign bus.board_out    = board_q;
    assign bus.location_out = loc_q;
    assign bus.rotation_out = rot_q;
    assign bus.pieces       = pieces_q;
    assign bus.game_over    = (state_q == GAMEOVER);

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: directed scenarios with literal expectations, then
// randomized play, all compared every cycle against a phase-level model.
module tb_game_ctrl;

    localparam int          DT   = 4;
    localparam logic [31:0] MASK = 32'h0000000F;

    logic clka    = 1'b0;
    logic restart = 1'b0;
    bit   cmp_en  = 1'b0;

    always #5 clka = ~clka;

    game_ctrl_if bus();

    game_ctrl #(.DROP_TICKS(DT), .TOP_ROW_MASK(MASK)) dut (
        .clka    (clka),
        .restart (restart),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase as an integer, pending command as -1 or a move code.
    int          m_state  = 0;
    int          m_old    = 0;
    int          m_cnt    = 0;
    int          m_pend   = -1;
    int          m_pieces = 0;
    logic [31:0] m_board  = '0;
    logic [4:0]  m_loc    = '0;
    logic [1:0]  m_rot    = '0;

    always @(posedge clka or posedge restart) begin
        if (restart) begin
            m_state <= 0; m_old <= 0; m_cnt <= 0; m_pend <= -1; m_pieces <= 0;
            m_board <= '0; m_loc <= '0; m_rot <= '0;
        end else begin
            automatic int          ns  = m_state;
            automatic int          nc  = 0;
            automatic int          np  = -1;
            automatic int          npc = m_pieces;
            automatic logic [31:0] nb  = m_board;
            automatic logic [4:0]  nl  = m_loc;
            automatic logic [1:0]  nr  = m_rot;
            automatic bit          gravity = (m_cnt == DT - 1);
            case (m_state)
                0: begin nl = bus.location_dp; nr = bus.rotation_dp; ns = 1; end
                1: begin
                    if (m_pend >= 0) begin
                        nb = bus.board_dp; nl = bus.location_dp; nr = bus.rotation_dp;
                        nc = gravity ? m_cnt : m_cnt + 1;
                    end else begin
                        np = bus.btn_rotate ? 3 : bus.btn_left ? 1 : bus.btn_right ? 2 : -1;
                        if (gravity) begin
                            nb = bus.board_dp; nl = bus.location_dp; nr = bus.rotation_dp;
                            nc = 0;
                            if (bus.touched) ns = 2;
                        end else begin
                            nc = m_cnt + 1;
                        end
                    end
                end
                2: begin nb = bus.board_dp; npc = (m_pieces < 255) ? m_pieces + 1 : 255; ns = 3; end
                3: begin nb = bus.board_dp; ns = bus.error_in ? 5 : 4; end
                4: begin nr = '0; ns = ((m_board & MASK) != 0) ? 5 : 0; end
                default: begin
                    if (bus.btn_start) begin
                        nb = '0; nl = '0; nr = '0; npc = 0; ns = 0;
                    end
                end
            endcase
            m_old <= m_state; m_state <= ns; m_cnt <= nc; m_pend <= np; m_pieces <= npc;
            m_board <= nb; m_loc <= nl; m_rot <= nr;
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clka) begin
        if (cmp_en) begin
            chk("state",     32'(bus.state),        32'(m_state));
            chk("old_state", 32'(bus.old_state),    32'(m_old));
            chk("move",      32'(bus.move),         (m_state == 1 && m_pend >= 0) ? 32'(m_pend) : 32'd0);
            chk("board",     bus.board_out,         m_board);
            chk("location",  32'(bus.location_out), 32'(m_loc));
            chk("rotation",  32'(bus.rotation_out), 32'(m_rot));
            chk("pieces",    32'(bus.pieces),       32'(m_pieces));
            chk("game_over", 32'(bus.game_over),    (m_state == 5) ? 32'd1 : 32'd0);
        end
    end

    task automatic step();
        @(posedge clka);
        #1;
    endtask

    task automatic wait_state(input int s, input int lim, input string nm);
        int n = 0;
        while (32'(bus.state) != 32'(s) && n < lim) begin
            step();
            n++;
        end
        chk(nm, 32'(bus.state), 32'(s));
    endtask

    task automatic clr_btn();
        bus.btn_left = 1'b0; bus.btn_right = 1'b0; bus.btn_rotate = 1'b0; bus.btn_start = 1'b0;
    endtask

    initial begin
        clr_btn();
        bus.touched = 1'b0; bus.error_in = 1'b0;
        bus.board_dp = '0; bus.location_dp = '0; bus.rotation_dp = '0;
        #1 restart = 1'b1;
        #1 cmp_en = 1'b1;
        step(); step();
        chk("rst_state",  32'(bus.state), 32'd0);
        chk("rst_board",  bus.board_out, 32'd0);
        chk("rst_pieces", 32'(bus.pieces), 32'd0);
        chk("rst_move",   32'(bus.move), 32'd0);
        restart = 1'b0;

        // Release: GEN then MOVE, old_state one behind
        step();
        chk("t1_state", 32'(bus.state), 32'd1);
        chk("t1_old",   32'(bus.old_state), 32'd0);
        chk("t1_move",  32'(bus.move), 32'd0);
        chk("t1_board", bus.board_out, 32'd0);

        // Left + rotate together: rotate wins, issued once
        bus.location_dp = 5'd6; bus.rotation_dp = 2'd1; bus.board_dp = 32'h0000_1230;
        bus.btn_left = 1'b1; bus.btn_rotate = 1'b1;
        step(); clr_btn();
        chk("t2_move", 32'(bus.move), 32'd3);
        step();
        chk("t2_once", 32'(bus.move), 32'd0);
        chk("t2_loc",  32'(bus.location_out), 32'd6);
        chk("t2_rot",  32'(bus.rotation_out), 32'd1);
        chk("t2_board", bus.board_out, 32'h0000_1230);
        step();
        chk("t2_none", 32'(bus.move), 32'd0);

        // Touched held: landing sequence, then exactly four MOVE cycles
        bus.touched = 1'b1;
        wait_state(2, 20, "t3_land");
        step(); chk("t3_clear", 32'(bus.state), 32'd3); chk("t3_pieces", 32'(bus.pieces), 32'd1);
        step(); chk("t3_nb",    32'(bus.state), 32'd4);
        step(); chk("t3_gen",   32'(bus.state), 32'd0);
        step(); chk("t3_move",  32'(bus.state), 32'd1);
        for (int k = 0; k < 3; k++) begin
            step(); chk("t3_hold", 32'(bus.state), 32'd1);
        end
        step(); chk("t3_tick4", 32'(bus.state), 32'd2);
        step(); chk("t3_pieces2", 32'(bus.pieces), 32'd2);
        bus.touched = 1'b0;
        step(); step(); step();
        chk("t4_move_entry", 32'(bus.state), 32'd1);

        // Right pending on the tick cycle: command first, tick next cycle
        step(); step();
        bus.btn_right = 1'b1; bus.touched = 1'b1; bus.location_dp = 5'd9;
        step(); clr_btn();
        chk("t4_cmd_move",  32'(bus.move), 32'd2);
        chk("t4_cmd_state", 32'(bus.state), 32'd1);
        step();
        chk("t4_defer_state", 32'(bus.state), 32'd1);
        chk("t4_defer_move",  32'(bus.move), 32'd0);
        chk("t4_loc",         32'(bus.location_out), 32'd9);
        step();
        chk("t4_land", 32'(bus.state), 32'd2);

        // Spawn row occupied: game over, stray buttons ignored, start resets
        bus.board_dp = 32'h0000_0003; bus.touched = 1'b0;
        step(); chk("t5_clear", 32'(bus.state), 32'd3); chk("t5_board", bus.board_out, 32'h3);
        step(); chk("t5_nb",    32'(bus.state), 32'd4);
        step(); chk("t5_over",  32'(bus.state), 32'd5); chk("t5_go", 32'(bus.game_over), 32'd1);
        bus.btn_left = 1'b1; bus.btn_rotate = 1'b1;
        step(); clr_btn();
        chk("t5_ignore", 32'(bus.state), 32'd5);
        bus.btn_start = 1'b1; bus.board_dp = '0;
        step(); clr_btn();
        chk("t5_gen",    32'(bus.state), 32'd0);
        chk("t5_board0", bus.board_out, 32'd0);
        chk("t5_pieces", 32'(bus.pieces), 32'd0);
        chk("t5_go0",    32'(bus.game_over), 32'd0);

        // Restart mid-MOVE with a command in flight
        bus.touched = 1'b1;
        wait_state(2, 20, "t6_land");
        bus.touched = 1'b0;
        step(); step(); step();
        step(); chk("t6_move", 32'(bus.state), 32'd1);
        bus.btn_left = 1'b1;
        step(); clr_btn();
        chk("t6_left", 32'(bus.move), 32'd1);
        restart = 1'b1;
        #1;
        chk("t6_rst_state",  32'(bus.state), 32'd0);
        chk("t6_rst_old",    32'(bus.old_state), 32'd0);
        chk("t6_rst_move",   32'(bus.move), 32'd0);
        chk("t6_rst_loc",    32'(bus.location_out), 32'd0);
        chk("t6_rst_pieces", 32'(bus.pieces), 32'd0);
        step(); step();
        restart = 1'b0;

        // Datapath error during CLEAR
        bus.touched = 1'b1;
        wait_state(2, 20, "t6_land2");
        bus.touched = 1'b0;
        step(); chk("t6_clear", 32'(bus.state), 32'd3);
        bus.error_in = 1'b1;
        step(); bus.error_in = 1'b0;
        chk("t6_err_over", 32'(bus.state), 32'd5);
        chk("t6_err_go",   32'(bus.game_over), 32'd1);
        bus.btn_start = 1'b1;
        step(); clr_btn();

        // Randomized play
        for (int i = 0; i < 3000; i++) begin
            bus.btn_left    = ($urandom_range(0, 7) == 0);
            bus.btn_right   = ($urandom_range(0, 7) == 0);
            bus.btn_rotate  = ($urandom_range(0, 7) == 0);
            bus.btn_start   = ($urandom_range(0, 3) == 0);
            bus.touched     = ($urandom_range(0, 2) == 0);
            bus.error_in    = ($urandom_range(0, 7) == 0);
            bus.board_dp    = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & ~MASK);
            bus.location_dp = 5'($urandom);
            bus.rotation_dp = 2'($urandom);
            restart         = ($urandom_range(0, 499) == 0);
            step();
        end
        restart = 1'b0;
        clr_btn();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
